// File: rtl/wash_pkg.sv
// Shared types and display/light codes for the wash_run controller.
package wash_pkg;

    typedef enum logic [2:0] {IDLE, CHECK, REJECT, WASH, RINSE, SPIN, DONE} state_t;

    localparam logic [3:0] DIG_MINUS = 4'd10;
    localparam logic [3:0] DIG_P     = 4'd11;
    localparam logic [3:0] DIG_BLANK = 4'd15;

    localparam logic [2:0] LT_OFF   = 3'b000;
    localparam logic [2:0] LT_WASH  = 3'b001;
    localparam logic [2:0] LT_RINSE = 3'b011;
    localparam logic [2:0] LT_SPIN  = 3'b111;

endpackage

// File: rtl/wash_run_if.sv
// Job-entry handshake plus display/status bundle between the entry stage and wash_run.
interface wash_run_if;
    logic       start_vld;
    logic       start_rdy;
    logic [3:0] bal_d1;
    logic [3:0] bal_d2;
    logic [3:0] bal_d3;
    logic [1:0] mode;
    logic       ack_pls;
    logic       pause_pls;
    logic       busy;
    logic       done_pls;
    logic [9:0] change;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic [2:0] st_light;

    modport master (
        output start_vld, bal_d1, bal_d2, bal_d3, mode, ack_pls, pause_pls,
        input  start_rdy, busy, done_pls, change, dig0, dig1, dig2, dig3, st_light
    );

    modport slave (
        input  start_vld, bal_d1, bal_d2, bal_d3, mode, ack_pls, pause_pls,
        output start_rdy, busy, done_pls, change, dig0, dig1, dig2, dig3, st_light
    );
endinterface

// File: rtl/bin2bcd3.sv
// Combinational 10-bit binary (0..999) to three BCD digits.
module bin2bcd3 (
    input  logic [9:0] bin_i,
    output logic [3:0] bcd1_o,
    output logic [3:0] bcd2_o,
    output logic [3:0] bcd3_o
);
    always_comb begin
        bcd1_o = 4'(bin_i % 10'd10);
        bcd2_o = 4'((bin_i / 10'd10) % 10'd10);
        bcd3_o = 4'(bin_i / 10'd100);
    end
endmodule

// File: rtl/wash_run.sv
// Wash job controller: prices a BCD balance, rejects or runs WASH->RINSE->SPIN, reports change.
// Optional pause feature enabled by defining WASH_RUN_PAUSE_EN.
module wash_run
    import wash_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 100_000_000,
    parameter int unsigned PRICE_BASE  = 5,
    parameter int unsigned WASH_S      = 30,
    parameter int unsigned RINSE_S     = 20,
    parameter int unsigned SPIN_S      = 10,
    parameter int unsigned REJECT_S    = 2
) (
    input  logic        clk,
    input  logic        rst,
    wash_run_if.slave   bus
);
    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       secs_q, secs_d;
    logic [9:0]       amt_q, amt_d;
    logic [9:0]       change_q, change_d;
    logic             done_q, done_d;
    logic [3:0]       bal1_q, bal1_d, bal2_q, bal2_d, bal3_q, bal3_d;
    logic [1:0]       mode_q, mode_d;
    logic             paused_q;

    logic             timed, running, tick, last_tick, bad_digit;
    logic [9:0]       mode_p1, price, bal, remaining, bcd_val;
    logic [3:0]       bcd1, bcd2, bcd3;

`ifdef WASH_RUN_PAUSE_EN
    logic paused_d;
`else
    logic unused_pause;
    assign unused_pause = bus.pause_pls;
    assign paused_q     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            secs_q   <= '0;
            amt_q    <= '0;
            change_q <= '0;
            done_q   <= 1'b0;
            bal1_q   <= '0;
            bal2_q   <= '0;
            bal3_q   <= '0;
            mode_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            secs_q   <= secs_d;
            amt_q    <= amt_d;
            change_q <= change_d;
            done_q   <= done_d;
            bal1_q   <= bal1_d;
            bal2_q   <= bal2_d;
            bal3_q   <= bal3_d;
            mode_q   <= mode_d;
        end
    end

`ifdef WASH_RUN_PAUSE_EN
    always_ff @(posedge clk) begin
        if (rst) paused_q <= 1'b0;
        else     paused_q <= paused_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        secs_d    = secs_q;
        amt_d     = amt_q;
        change_d  = change_q;
        done_d    = 1'b0;
        bal1_d    = bal1_q;
        bal2_d    = bal2_q;
        bal3_d    = bal3_q;
        mode_d    = mode_q;
`ifdef WASH_RUN_PAUSE_EN
        paused_d  = paused_q;
`endif
        running   = (state_q == WASH) || (state_q == RINSE) || (state_q == SPIN);
        timed     = running || (state_q == REJECT);
        tick      = timed && !paused_q && (cnt_q == CNT_LAST);
        last_tick = tick && (secs_q == 10'd1);
        mode_p1   = {8'd0, mode_q} + 10'd1;
        price     = 10'(PRICE_BASE) * mode_p1;
        bal       = {6'd0, bal3_q} * 10'd100 + {6'd0, bal2_q} * 10'd10 + {6'd0, bal1_q};
        bad_digit = (bal1_q > 4'd9) || (bal2_q > 4'd9) || (bal3_q > 4'd9);

        if (timed && !paused_q) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) secs_d = secs_q - 10'd1;
`ifdef WASH_RUN_PAUSE_EN
        if (running && bus.pause_pls) paused_d = !paused_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start_vld) begin
                    bal1_d   = bus.bal_d1;
                    bal2_d   = bus.bal_d2;
                    bal3_d   = bus.bal_d3;
                    mode_d   = bus.mode;
                    change_d = '0;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                cnt_d = '0;
                if (bad_digit || (bal < price)) begin
                    amt_d   = bad_digit ? price : price - bal;
                    secs_d  = 10'(REJECT_S);
                    state_d = REJECT;
                end else begin
                    amt_d   = bal - price;
                    secs_d  = 10'(WASH_S) * mode_p1;
                    state_d = WASH;
                end
            end
            REJECT: if (last_tick) state_d = IDLE;
            WASH: begin
                if (last_tick) begin
                    secs_d  = 10'(RINSE_S);
                    state_d = RINSE;
                end
            end
            RINSE: begin
                if (last_tick) begin
                    secs_d  = 10'(SPIN_S);
                    state_d = SPIN;
                end
            end
            SPIN: begin
                if (last_tick) begin
                    change_d = amt_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: if (bus.ack_pls) state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef WASH_RUN_PAUSE_EN
        if (last_tick) paused_d = 1'b0;
`endif
    end

    // Remaining run time counts the current phase plus every phase still ahead.
    always_comb begin
        case (state_q)
            WASH:    remaining = secs_q + 10'(RINSE_S) + 10'(SPIN_S);
            RINSE:   remaining = secs_q + 10'(SPIN_S);
            default: remaining = secs_q;
        endcase
        bcd_val = running ? remaining : amt_q;
    end

    bin2bcd3 u_bcd (
        .bin_i  (bcd_val),
        .bcd1_o (bcd1),
        .bcd2_o (bcd2),
        .bcd3_o (bcd3)
    );

    always_comb begin
        bus.dig0     = DIG_BLANK;
        bus.dig1     = DIG_BLANK;
        bus.dig2     = DIG_BLANK;
        bus.dig3     = DIG_BLANK;
        bus.st_light = LT_OFF;
        case (state_q)
            REJECT: bus.dig0 = DIG_MINUS;
            WASH:   bus.st_light = LT_WASH;
            RINSE:  bus.st_light = LT_RINSE;
            SPIN:   bus.st_light = LT_SPIN;
            default: ;
        endcase
        if (running && paused_q) bus.dig0 = DIG_P;
        if (timed || (state_q == DONE)) begin
            bus.dig1 = bcd1;
            bus.dig2 = bcd2;
            bus.dig3 = bcd3;
        end
    end

    assign bus.start_rdy = (state_q == IDLE);
    assign bus.busy      = running;
    assign bus.done_pls  = done_q;
    assign bus.change    = change_q;

endmodule

// File: tb/tb_wash_run.sv
// Self-checking bench for wash_run with a small-parameter build; reference model computes job outcomes.
module tb_wash_run;
    localparam int TICK = 4;
`ifdef WASH_RUN_PAUSE_EN
    localparam int PDLY = 20;
    localparam int PDIG = 11;
`else
    localparam int PDLY = 0;
    localparam int PDIG = 15;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    wash_run_if wif();

    wash_run #(
        .TICK_CYCLES(TICK), .PRICE_BASE(5), .WASH_S(3),
        .RINSE_S(2), .SPIN_S(1), .REJECT_S(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (wif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        nvec++;
        assert (obs === 32'(exp)) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_digits(input string tag, input int d0, input int val);
        chk({tag, "_dig0"}, 32'(wif.dig0), d0);
        chk({tag, "_dig3"}, 32'(wif.dig3), (val / 100) % 10);
        chk({tag, "_dig2"}, 32'(wif.dig2), (val / 10) % 10);
        chk({tag, "_dig1"}, 32'(wif.dig1), val % 10);
    endtask

    task automatic chk_idle(input string tag, input int exp_change);
        chk({tag, "_rdy"},   32'(wif.start_rdy), 1);
        chk({tag, "_busy"},  32'(wif.busy), 0);
        chk({tag, "_light"}, 32'(wif.st_light), 0);
        chk({tag, "_chg"},   32'(wif.change), exp_change);
        chk({tag, "_d0"},    32'(wif.dig0), 15);
        chk({tag, "_d1"},    32'(wif.dig1), 15);
        chk({tag, "_d3"},    32'(wif.dig3), 15);
    endtask

    task automatic accept(input int d3, input int d2, input int d1, input int m);
        wif.bal_d3    = 4'(d3);
        wif.bal_d2    = 4'(d2);
        wif.bal_d1    = 4'(d1);
        wif.mode      = 2'(m);
        wif.start_vld = 1'b1;
        step();
        wif.start_vld = 1'b0;
        chk("check_rdy", 32'(wif.start_rdy), 0);
        step();
    endtask

    // Reference model: price, balance and phase lengths straight from the pricing/timing rules.
    task automatic run_job(input int d3, input int d2, input int d1, input int m, input int pause_at);
        int price, bal, amt, tot_s, wl, rl, done_k, dly, k;
        bit bad, rej;
        price = 5 * (m + 1);
        bad   = (d3 > 9) || (d2 > 9) || (d1 > 9);
        bal   = 100 * d3 + 10 * d2 + d1;
        rej   = bad || (bal < price);
        amt   = bad ? price : (bal < price ? price - bal : bal - price);
        tot_s = 3 * (m + 1) + 2 + 1;
        wl    = TICK * 3 * (m + 1);
        rl    = TICK * 2;
        dly   = (pause_at > 0) ? PDLY : 0;
        done_k = TICK * tot_s + dly;

        chk("pre_rdy", 32'(wif.start_rdy), 1);
        accept(d3, d2, d1, m);
        if (rej) begin
            chk_digits("rej", 10, amt);
            chk("rej_busy", 32'(wif.busy), 0);
            chk("rej_light", 32'(wif.st_light), 0);
            k = 0;
            while (!wif.start_rdy && k < 100) begin
                if (wif.busy) chk("rej_busy_run", 32'(wif.busy), 0);
                step();
                k++;
            end
            chk("rej_len", k, 2 * TICK);
            chk_idle("rej_end", 0);
        end else begin
            chk("run_light0", 32'(wif.st_light), 1);
            chk("run_busy0", 32'(wif.busy), 1);
            chk_digits("run0", 15, tot_s);
            k = 0;
            while (k < 400) begin
                if (k == wl + dly)      chk("light_rinse", 32'(wif.st_light), 3);
                if (k == wl + rl + dly) chk("light_spin", 32'(wif.st_light), 7);
                if ((k % TICK == 0) && k > 0 && k < TICK * tot_s && (pause_at == 0 || k <= pause_at))
                    chk_digits("remain", 15, tot_s - k / TICK);
                if (pause_at > 0 && k == pause_at + 10) begin
                    chk("pause_dig0", 32'(wif.dig0), PDIG);
                    chk("pause_busy", 32'(wif.busy), 1);
                end
                if (wif.done_pls) break;
                wif.pause_pls = (pause_at > 0 && (k == pause_at || k == pause_at + 20));
                wif.ack_pls   = (k == 3);
                wif.start_vld = (k == 3);
                wif.bal_d3 = 4'd9; wif.bal_d2 = 4'd9; wif.bal_d1 = 4'd9;
                step();
                wif.pause_pls = 1'b0;
                wif.ack_pls   = 1'b0;
                wif.start_vld = 1'b0;
                k++;
            end
            chk("done_at", k, done_k);
            chk("done_chg", 32'(wif.change), amt);
            chk_digits("done", 15, amt);
            chk("done_light", 32'(wif.st_light), 0);
            chk("done_busy", 32'(wif.busy), 0);
            step();
            chk("done_once", 32'(wif.done_pls), 0);
            chk("done_hold_rdy", 32'(wif.start_rdy), 0);
            wif.ack_pls = 1'b1;
            step();
            wif.ack_pls = 1'b0;
            chk_idle("ack", amt);
        end
    endtask

    initial begin
        int d3, d2, d1, m;
        wif.start_vld = 1'b0;
        wif.bal_d1 = '0; wif.bal_d2 = '0; wif.bal_d3 = '0;
        wif.mode = '0; wif.ack_pls = 1'b0; wif.pause_pls = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_idle("reset", 0);
        chk("reset_done", 32'(wif.done_pls), 0);

        // ack while idle has no effect
        wif.ack_pls = 1'b1;
        step();
        wif.ack_pls = 1'b0;
        chk_idle("idle_ack", 0);

        run_job(0, 1, 2, 1, 0);
        run_job(0, 0, 4, 0, 0);
        run_job(0, 10, 0, 0, 0);
        run_job(0, 0, 5, 0, 0);
        run_job(0, 1, 2, 1, 5);

        // Reset in the middle of RINSE abandons the job.
        accept(0, 1, 2, 1);
        for (int i = 0; i < 26; i++) step();
        chk("pre_rst_light", 32'(wif.st_light), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("mid_rst", 0);
        for (int i = 0; i < 50; i++) begin
            if (wif.done_pls) chk("rst_no_done", 32'(wif.done_pls), 0);
            step();
        end

        for (int j = 0; j < 10; j++) begin
            d3 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
            d2 = int'($urandom_range(0, 2));
            d1 = int'($urandom_range(0, 9));
            m  = int'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) d1 = int'($urandom_range(10, 15));
            run_job(d3, d2, d1, m, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
